cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control_pkg.sv | 38 +++
 rtl/cache_control.sv | 192 +++++++++++++++++++
 tb/tb_cache_control.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_control_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_types (package)
// Brief  : Shared types for the cache controller: FSM state encoding and
//          datapath mux select encodings.
// Rev    : 1.0  initial release
// ============================================================================
package cache_types;

  // Controller states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_RELOAD    = 3'd4
  } state_t;

  // Way select for data/dirty array writes.
  typedef enum logic {
    WAY_HIT = 1'b0,
    WAY_LRU = 1'b1
  } waymux_t;

  // Source of data written into the data array.
  typedef enum logic {
    DATA_CPU = 1'b0,
    DATA_MEM = 1'b1
  } datamux_t;

  // Source of the physical memory address.
  typedef enum logic {
    PMAD_CPU = 1'b0,
    PMAD_TAG = 1'b1
  } pmadmux_t;

endpackage : cache_types
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module : cache_control
// Brief  : Write-back, write-allocate cache controller FSM
//          (IDLE -> COMPARE -> [WRITEBACK] -> ALLOCATE -> RELOAD -> COMPARE).
//          Drives datapath load strobes and mux selects; all outputs are
//          decoded from the current state and inputs.
// Config : CACHE_PERF_CNT_EN - when defined, adds saturating hit/miss/
//          writeback counters (hit_count, miss_count, wb_count).
// Ports  : clk, rst (sync, active-high)
//          mem_read, mem_write -> mem_resp            CPU side
//          pmem_read, pmem_write <- pmem_resp         memory side
//          SIGHIT, SIGDIRTY                           datapath status
//          LD_VALID, LD_DIRTY, LD_TAG, LD_DATA, LD_PLRU, DIRTYVAL
//          DIRTYWMUX, DATAWMUX, DATAMUX, PMADMUX      datapath control
// Rev    : 1.0  initial release
// ============================================================================
module cache_control
  import cache_types::*;
#(
  parameter int unsigned cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 SIGHIT,
  input  logic                 SIGDIRTY,
  output logic                 LD_VALID,
  output logic                 LD_DIRTY,
  output logic                 LD_TAG,
  output logic                 LD_DATA,
  output logic                 LD_PLRU,
  output logic                 DIRTYVAL,
  output logic                 DIRTYWMUX,
  output logic                 DATAWMUX,
  output logic                 DATAMUX,
`ifdef CACHE_PERF_CNT_EN
  output logic                 PMADMUX,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count,
  output logic [cnt_width-1:0] wb_count
`else
  output logic                 PMADMUX
`endif
);

  state_t   state_q, state_d;
  waymux_t  dirtywmux, datawmux;
  datamux_t datamux;
  pmadmux_t pmadmux;
  logic     req;

  // Simultaneous read and write is treated as a write.
  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    LD_VALID   = 1'b0;
    LD_DIRTY   = 1'b0;
    LD_TAG     = 1'b0;
    LD_DATA    = 1'b0;
    LD_PLRU    = 1'b0;
    DIRTYVAL   = 1'b0;
    dirtywmux  = WAY_HIT;
    datawmux   = WAY_HIT;
    datamux    = DATA_CPU;
    pmadmux    = PMAD_CPU;

    // Reset masks every output in the reset cycle itself, so a pending
    // memory request is dropped immediately rather than one cycle late.
    if (rst) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // One cycle here lets the synchronous tag/data arrays read.
          if (req) state_d = S_COMPARE;
        end

        S_COMPARE: begin
          if (!req) begin
            state_d = S_IDLE;
          end else if (SIGHIT) begin
            mem_resp = 1'b1;
            LD_PLRU  = 1'b1;
            if (mem_write) begin
              LD_DATA  = 1'b1;
              LD_DIRTY = 1'b1;
              DIRTYVAL = 1'b1;
            end
            state_d = S_IDLE;
          end else if (SIGDIRTY) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_ALLOCATE;
          end
        end

        S_WRITEBACK: begin
          pmem_write = 1'b1;
          pmadmux    = PMAD_TAG;
          if (pmem_resp) state_d = S_ALLOCATE;
        end

        S_ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            // Fill the LRU way with a clean line from memory.
            LD_DATA   = 1'b1;
            LD_TAG    = 1'b1;
            LD_VALID  = 1'b1;
            LD_DIRTY  = 1'b1;
            DIRTYVAL  = 1'b0;
            datamux   = DATA_MEM;
            datawmux  = WAY_LRU;
            dirtywmux = WAY_LRU;
            state_d   = S_RELOAD;
          end
        end

        S_RELOAD: begin
          // Arrays re-read the freshly filled line; next COMPARE hits.
          state_d = S_COMPARE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign DIRTYWMUX = dirtywmux;
  assign DATAWMUX  = datawmux;
  assign DATAMUX   = datamux;
  assign PMADMUX   = pmadmux;

`ifdef CACHE_PERF_CNT_EN
  logic                 hit_evt, miss_evt, wb_evt;
  logic [cnt_width-1:0] hit_count_q, hit_count_d;
  logic [cnt_width-1:0] miss_count_q, miss_count_d;
  logic [cnt_width-1:0] wb_count_q, wb_count_d;

  assign hit_evt  = !rst && (state_q == S_COMPARE) && req && SIGHIT;
  assign miss_evt = !rst && (state_q == S_COMPARE) && req && !SIGHIT;
  assign wb_evt   = miss_evt && SIGDIRTY;

  // Saturating increments: a counter at all-ones holds.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    if (hit_evt  && (hit_count_q  != '1)) hit_count_d  = hit_count_q  + 1'b1;
    if (miss_evt && (miss_count_q != '1)) miss_count_d = miss_count_q + 1'b1;
    if (wb_evt   && (wb_count_q   != '1)) wb_count_d   = wb_count_q   + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`endif

endmodule : cache_control
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_control
// Brief  : Self-checking bench for cache_control. A per-cycle vector table
//          covers the main flows; short hand sequences cover latency and
//          (with CACHE_PERF_CNT_EN) counter behaviour.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cache_control;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, pmem_resp, SIGHIT, SIGDIRTY;
  logic mem_resp, pmem_read, pmem_write;
  logic LD_VALID, LD_DIRTY, LD_TAG, LD_DATA, LD_PLRU, DIRTYVAL;
  logic DIRTYWMUX, DATAWMUX, DATAMUX, PMADMUX;
`ifdef CACHE_PERF_CNT_EN
  logic [3:0] hit_count, miss_count, wb_count;
`endif

  always #5 clk = ~clk;

  cache_control #(.cnt_width(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .SIGHIT(SIGHIT), .SIGDIRTY(SIGDIRTY),
    .LD_VALID(LD_VALID), .LD_DIRTY(LD_DIRTY), .LD_TAG(LD_TAG),
    .LD_DATA(LD_DATA), .LD_PLRU(LD_PLRU), .DIRTYVAL(DIRTYVAL),
    .DIRTYWMUX(DIRTYWMUX), .DATAWMUX(DATAWMUX), .DATAMUX(DATAMUX),
`ifdef CACHE_PERF_CNT_EN
    .PMADMUX(PMADMUX),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`else
    .PMADMUX(PMADMUX)
`endif
  );

  // Output bit order:
  // [12]mem_resp [11]pmem_read [10]pmem_write [9]LD_VALID [8]LD_DIRTY
  // [7]LD_TAG [6]LD_DATA [5]LD_PLRU [4]DIRTYVAL [3]DIRTYWMUX [2]DATAWMUX
  // [1]DATAMUX [0]PMADMUX
  localparam logic [12:0] E_0     = 13'h0000;
  localparam logic [12:0] E_ALLOC = 13'h0800;
  localparam logic [12:0] E_FILL  = 13'h0BCE;
  localparam logic [12:0] E_RHIT  = 13'h1020;
  localparam logic [12:0] E_WHIT  = 13'h1170;
  localparam logic [12:0] E_WB    = 13'h0401;

  typedef struct {
    logic        rst, rd, wr, hit, dirty, presp;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [12:0] outs();
    return {mem_resp, pmem_read, pmem_write, LD_VALID, LD_DIRTY, LD_TAG,
            LD_DATA, LD_PLRU, DIRTYVAL, DIRTYWMUX, DATAWMUX, DATAMUX, PMADMUX};
  endfunction

  task automatic add(input logic r, input logic rd, input logic wr,
                     input logic hit, input logic dirty, input logic presp,
                     input logic [12:0] exp);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.hit = hit; v.dirty = dirty;
    v.presp = presp; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic hit, input logic dirty, input logic presp);
    rst = r; mem_read = rd; mem_write = wr;
    SIGHIT = hit; SIGDIRTY = dirty; pmem_resp = presp;
  endtask

  // Called just after a falling edge: settle, optionally check, then
  // advance to the next falling edge (a rising edge happens in between).
  task automatic step(input logic r, input logic rd, input logic wr,
                      input logic hit, input logic dirty, input logic presp);
    drive(r, rd, wr, hit, dirty, presp);
    #1;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int alloc_cycles;
    bit seen;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //   rst rd wr hit drt prs  expected
    add(1, 1, 0, 0, 0, 0, E_0);      // reset, request ignored
    add(1, 0, 0, 0, 0, 0, E_0);
    add(0, 0, 0, 0, 0, 0, E_0);      // IDLE
    // cold read miss, clean victim
    add(0, 1, 0, 0, 0, 0, E_0);      // IDLE -> COMPARE
    add(0, 1, 0, 0, 0, 0, E_0);      // COMPARE miss -> ALLOCATE
    add(0, 1, 0, 0, 0, 0, E_ALLOC);
    add(0, 1, 0, 0, 0, 0, E_ALLOC);
    add(0, 1, 0, 0, 0, 0, E_ALLOC);
    add(0, 1, 0, 0, 0, 0, E_ALLOC);
    add(0, 1, 0, 0, 0, 1, E_FILL);   // 5th cycle: memory answers
    add(0, 1, 0, 0, 0, 0, E_0);      // RELOAD
    add(0, 1, 0, 1, 0, 0, E_RHIT);   // COMPARE hit
    // write hit
    add(0, 0, 1, 1, 0, 0, E_0);
    add(0, 0, 1, 1, 0, 0, E_WHIT);
    // dirty miss: writeback then allocate
    add(0, 1, 0, 0, 1, 0, E_0);
    add(0, 1, 0, 0, 1, 0, E_0);      // -> WRITEBACK
    add(0, 1, 0, 0, 1, 0, E_WB);
    add(0, 1, 0, 0, 1, 0, E_WB);
    add(0, 1, 0, 0, 1, 1, E_WB);     // -> ALLOCATE
    add(0, 1, 0, 0, 0, 0, E_ALLOC);
    add(0, 1, 0, 0, 0, 1, E_FILL);
    add(0, 1, 0, 0, 0, 0, E_0);
    add(0, 1, 0, 1, 0, 0, E_RHIT);
    // spurious pmem_resp in IDLE and COMPARE hit
    add(0, 0, 0, 0, 0, 1, E_0);
    add(0, 1, 0, 1, 0, 1, E_0);
    add(0, 1, 0, 1, 0, 1, E_RHIT);
    // read and write together behave as a write
    add(0, 1, 1, 1, 0, 0, E_0);
    add(0, 1, 1, 1, 0, 0, E_WHIT);
    // COMPARE with request withdrawn returns to IDLE quietly
    add(0, 1, 0, 1, 0, 0, E_0);
    add(0, 0, 0, 1, 0, 0, E_0);
    add(0, 0, 1, 1, 0, 0, E_0);      // must be IDLE again
    add(0, 0, 1, 1, 0, 0, E_WHIT);
    // reset in third ALLOCATE cycle
    add(0, 1, 0, 0, 0, 0, E_0);
    add(0, 1, 0, 0, 0, 0, E_0);
    add(0, 1, 0, 0, 0, 0, E_ALLOC);
    add(0, 1, 0, 0, 0, 0, E_ALLOC);
    add(1, 1, 0, 0, 0, 0, E_0);
    add(0, 0, 0, 0, 0, 1, E_0);      // late pmem_resp ignored
    add(0, 0, 0, 0, 0, 0, E_0);
    // reset mid-WRITEBACK
    add(0, 1, 0, 0, 1, 0, E_0);
    add(0, 1, 0, 0, 1, 0, E_0);
    add(0, 1, 0, 0, 1, 0, E_WB);
    add(1, 1, 0, 0, 1, 0, E_0);
    add(0, 0, 0, 0, 0, 1, E_0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].hit,
            vecs[i].dirty, vecs[i].presp);
      #1;
      check($sformatf("vec%0d", i), {19'd0, outs()}, {19'd0, vecs[i].exp});
      if (pmem_read && pmem_write) check("pmem_excl", 32'd1, 32'd0);
      @(negedge clk);
    end

    // Latency: read hit answers in the cycle after the request is seen.
    step(1, 0, 0, 0, 0, 0);
    seen = 1'b0;
    for (cyc = 0; cyc < 10 && !seen; cyc++) begin
      drive(0, 1, 0, 1, 0, 0);
      #1;
      if (mem_resp) begin
        seen = 1'b1;
        check("hit_latency", cyc, 1);
      end
      @(negedge clk);
    end
    if (!seen) check("hit_timeout", 0, 1);

    // Latency: clean miss, memory answers on the 5th ALLOCATE cycle.
    step(0, 0, 0, 0, 0, 0);
    seen = 1'b0;
    alloc_cycles = 0;
    for (cyc = 0; cyc < 30 && !seen; cyc++) begin
      drive(0, 1, 0, (alloc_cycles >= 5), 0, 0);
      #1;
      if (pmem_read) begin
        alloc_cycles++;
        if (alloc_cycles == 5) pmem_resp = 1'b1;
      end
      #1;
      if (mem_resp) begin
        seen = 1'b1;
        check("miss_latency", cyc, 8);
      end
      @(negedge clk);
    end
    if (!seen) check("miss_timeout", 0, 1);
    step(0, 0, 0, 0, 0, 0);

`ifdef CACHE_PERF_CNT_EN
    step(1, 0, 0, 0, 0, 0);
    #1;
    check("cnt_rst_hit", {28'd0, hit_count}, 0);
    check("cnt_rst_miss", {28'd0, miss_count}, 0);
    check("cnt_rst_wb", {28'd0, wb_count}, 0);
    // dirty miss, writeback, fill, final hit
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #1;
    check("cnt_wb", {28'd0, wb_count}, 1);
    check("cnt_miss", {28'd0, miss_count}, 1);
    check("cnt_hit1", {28'd0, hit_count}, 1);
    for (int k = 0; k < 14; k++) begin
      step(0, 1, 0, 1, 0, 0);
      step(0, 1, 0, 1, 0, 0);
    end
    #1;
    check("cnt_hit15", {28'd0, hit_count}, 15);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    #1;
    check("cnt_hit_sat", {28'd0, hit_count}, 15);
    check("cnt_miss_hold", {28'd0, miss_count}, 1);
    step(1, 0, 0, 0, 0, 0);
    #1;
    check("cnt_clear", {28'd0, hit_count}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cache_control
`default_nettype wire
